// File: rtl/echo_request_input.sv
// Echo request input: buffers inbound pipe messages and presents them as say calls.
// Define ECHO_REQUEST_INPUT_BADTAG_EN to drop and count messages whose tag is not 1.
module echo_request_input #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             pipe_enq__ENA,
    input  logic [95:0]      pipe_enq_v,
    output logic             pipe_enq__RDY,
    output logic             request_say__ENA,
    output logic [31:0]      request_say_meth,
    output logic [31:0]      request_say_v,
    input  logic             request_say__RDY,
    output logic [CNT_W-1:0] badtag_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] occ;
    logic             accept;
    logic             tag_ok;
    logic             store;
    logic             deliver;

    // Handshakes depend only on registered occupancy; reset forces the idle view.
    assign pipe_enq__RDY    = RST || (occ < OCC_W'(DEPTH));
    assign request_say__ENA = !RST && (occ != '0);
    assign accept           = pipe_enq__ENA && pipe_enq__RDY && !RST;
    assign deliver          = request_say__ENA && request_say__RDY;
    assign store            = accept && tag_ok;

    assign request_say_meth = mem[head][31:0];
    assign request_say_v    = mem[head][63:32];

`ifdef ECHO_REQUEST_INPUT_BADTAG_EN
    logic [CNT_W-1:0] bad_cnt;

    assign tag_ok       = (pipe_enq_v[31:0] == 32'd1);
    assign badtag_count = bad_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            bad_cnt <= '0;
        end else if (accept && !tag_ok && (bad_cnt != '1)) begin
            bad_cnt <= bad_cnt + 1'b1;
        end
    end
`else
    logic unused_tag;

    assign unused_tag   = ^pipe_enq_v[31:0];
    assign tag_ok       = 1'b1;
    assign badtag_count = '0;
`endif

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RST) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (store) begin
                tail <= tail + 1'b1;
            end
            if (deliver) begin
                head <= head + 1'b1;
            end
            if (store && !deliver) begin
                occ <= occ + 1'b1;
            end else if (!store && deliver) begin
                occ <= occ - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (store) begin
            mem[tail] <= pipe_enq_v[95:32];
        end
    end

endmodule

// File: tb/tb_echo_request_input.sv
// Scoreboard bench for echo_request_input: stimulus pushes expected {meth,v}, monitor pops on delivery.
// Saturation is exercised with a narrow counter when ECHO_REQUEST_INPUT_BADTAG_EN is defined.
module tb_echo_request_input;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pipeEna = 1'b0;
    logic [95:0]      pipeData = '0;
    logic             pipeRdy;
    logic             sayEna;
    logic [31:0]      sayMeth;
    logic [31:0]      sayV;
    logic             sayRdy = 1'b0;
    logic [CNT_W-1:0] badCount;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] expQ[$];
    int          modelOcc = 0;
    int          modelBad = 0;

    echo_request_input #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(clk),
        .RST(rst),
        .pipe_enq__ENA(pipeEna),
        .pipe_enq_v(pipeData),
        .pipe_enq__RDY(pipeRdy),
        .request_say__ENA(sayEna),
        .request_say_meth(sayMeth),
        .request_say_v(sayV),
        .request_say__RDY(sayRdy),
        .badtag_count(badCount)
    );

    always #5 clk = ~clk;

    function automatic bit tagAccepted(input logic [31:0] tag);
`ifdef ECHO_REQUEST_INPUT_BADTAG_EN
        return tag == 32'd1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Hold a message on the pipe until accepted; push its expected echo on acceptance.
    task automatic applyStimulus(input logic [31:0] tag, input logic [31:0] meth, input logic [31:0] v);
        int waited = 0;
        @(posedge clk);
        #1;
        pipeEna  = 1'b1;
        pipeData = {v, meth, tag};
        forever begin
            @(negedge clk);
            if (pipeRdy) begin
                if (tagAccepted(tag)) expQ.push_back({meth, v});
                break;
            end
            waited++;
            if (waited > 50) begin
                checkOutput("accept_timeout", 64'(waited), 64'd0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        pipeEna = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle model of occupancy and bad-tag count; checks handshakes and pops deliveries.
    always @(negedge clk) begin
        logic [63:0] exp;
        bit acc;
        if (rst) begin
            checkOutput("reset_say_ena", 64'(sayEna), 64'd0);
            checkOutput("reset_pipe_rdy", 64'(pipeRdy), 64'd1);
            modelOcc = 0;
            modelBad = 0;
            expQ.delete();
        end else begin
            checkOutput("pipe_rdy", 64'(pipeRdy), 64'(modelOcc < DEPTH));
            checkOutput("say_ena", 64'(sayEna), 64'(modelOcc > 0));
            checkOutput("badtag_count", 64'(badCount), 64'(modelBad));
            if (modelOcc > 0 && sayRdy) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_delivery", {sayMeth, sayV}, 64'hx);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("say_data", {sayMeth, sayV}, exp);
                end
                modelOcc--;
            end
            acc = pipeEna && (modelOcc + ((modelOcc > 0 && sayRdy) ? 1 : 0) < DEPTH);
            if (acc) begin
                if (tagAccepted(pipeData[31:0])) modelOcc++;
                else if (modelBad < (1 << CNT_W) - 1) modelBad++;
            end
        end
    end

    initial begin
        int waited;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single message: visible one cycle after acceptance, gone the next.
        sayRdy = 1'b1;
        applyStimulus(32'd1, 32'h0, 32'h5);
        idle(3);

        // Back-pressure: third message is held until the consumer releases.
        sayRdy = 1'b0;
        applyStimulus(32'd1, 32'h10, 32'h1);
        applyStimulus(32'd1, 32'h20, 32'h2);
        fork
            applyStimulus(32'd1, 32'h30, 32'h3);
            begin
                repeat (3) @(posedge clk);
                #1;
                sayRdy = 1'b1;
            end
        join
        idle(5);

        // Full buffer, delivery and enqueue in the same cycle.
        sayRdy = 1'b0;
        applyStimulus(32'd1, 32'hA1, 32'h11);
        applyStimulus(32'd1, 32'hA2, 32'h12);
        idle(2);
        fork
            begin
                @(posedge clk);
                #1;
                sayRdy = 1'b1;
            end
            applyStimulus(32'd1, 32'hA3, 32'h13);
        join
        idle(5);

        // Reset with two messages buffered and an enqueue in the reset cycle.
        sayRdy = 1'b0;
        applyStimulus(32'd1, 32'hB1, 32'h21);
        applyStimulus(32'd1, 32'hB2, 32'h22);
        idle(1);
        rst      = 1'b1;
        pipeEna  = 1'b1;
        pipeData = {32'hDEAD, 32'hBEEF, 32'd1};
        @(posedge clk);
        #1;
        rst     = 1'b0;
        pipeEna = 1'b0;
        sayRdy  = 1'b1;
        idle(4);

        // Non-unit tag: echoed in the default build, dropped and counted otherwise.
        applyStimulus(32'd7, 32'h77, 32'h4);
        idle(3);

`ifdef ECHO_REQUEST_INPUT_BADTAG_EN
        applyStimulus(32'd2, 32'h0, 32'h8);
        applyStimulus(32'd1, 32'h0, 32'h9);
        idle(3);
        checkOutput("badtag_after_two", 64'(badCount), 64'd2);
        for (int i = 0; i < 20; i++) applyStimulus(32'd3, 32'h0, 32'(i));
        idle(3);
        checkOutput("badtag_saturated", 64'(badCount), 64'd15);
`else
        checkOutput("badtag_tied_zero", 64'(badCount), 64'd0);
`endif

        waited = 0;
        while (expQ.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        #1;
        checkOutput("drain_pending", 64'(expQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/echo_request_input.md
ECHO_REQUEST_INPUT -- requirements
Module: echo_request_input

Interface
REQ-001 Parameter DEPTH, default 2, message buffer entries; power of two, >= 2.
REQ-002 Parameter CNT_W, default 16, width of bad-tag counter.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 pipe$enq__ENA  input  1  inbound message strobe from transport pipe.
REQ-006 pipe$enq$v  input  96  packed message: [31:0] tag, [63:32] meth, [95:64] v.
REQ-007 pipe$enq__RDY  output  1  buffer can accept a message this cycle.
REQ-008 request$say__ENA  output  1  decoded say call valid to user.
REQ-009 request$say$meth  output  32  meth field of head message.
REQ-010 request$say$v  output  32  v field of head message.
REQ-011 request$say__RDY  input  1  user accepts say call.
REQ-012 badtag$count  output  CNT_W  number of messages dropped for unknown tag.

Function
REQ-013 Pipe accept occurs in a cycle where pipe$enq__ENA && pipe$enq__RDY; ENA without RDY shall be ignored with no state change.
REQ-014 pipe$enq__RDY shall be 1 iff occupancy < DEPTH, from registered state only (no combinational path from request$say__RDY).
REQ-015 Accepted message with tag == 32'd1 shall be written to buffer tail as {v, meth}.
REQ-016 Accepted message with tag != 32'd1 shall not be written; badtag$count shall increment by 1, saturating at all-ones.
REQ-017 request$say__ENA shall be 1 iff occupancy > 0; meth and v shall present the head entry, held stable while ENA && !RDY.
REQ-018 Delivery occurs when request$say__ENA && request$say__RDY; head shall advance next cycle.
REQ-019 Latency: message accepted in cycle N shall appear on request$say__ENA no earlier than cycle N+1 (no bypass), with an empty buffer exactly N+1.
REQ-020 Messages shall be delivered in acceptance order, none duplicated or lost except REQ-016 drops.
REQ-021 Simultaneous accept and delivery: occupancy unchanged; both pointers advance, wrapping modulo DEPTH.
REQ-022 Full (occupancy == DEPTH) with delivery in same cycle: pipe$enq__RDY stays 0 that cycle; becomes 1 next cycle.
REQ-023 Bad-tag accept concurrent with delivery: occupancy decrements by 1, counter increments.
REQ-024 When buffer empty, meth and v outputs are don't-care but shall be driven (no X from uninitialised storage after reset is required only for ENA).

Reset
REQ-025 RST high at posedge CLK shall clear occupancy and both pointers and badtag$count to 0.
REQ-026 During and on the cycle after reset: request$say__ENA = 0, pipe$enq__RDY = 1 (first cycle after RST deasserts).
REQ-027 RST asserted mid-operation shall discard all buffered messages; none shall be delivered afterwards; a pipe accept in the reset cycle is discarded.
REQ-028 Buffer data storage need not be reset.

Configuration
REQ-029 Macro ECHO_REQUEST_INPUT_BADTAG_EN, when defined, enables tag checking and counting per REQ-015/REQ-016.
REQ-030 Without ECHO_REQUEST_INPUT_BADTAG_EN: tag field ignored, every accepted message buffered and delivered, badtag$count tied to 0, no counter register.

Verification
REQ-031 After reset, accept {v=32'h0000_0005, meth=32'h0000_0000, tag=1} at cycle N with say__RDY=1 -> request$say__ENA=1 at N+1 with meth=0, v=5; ENA=0 at N+2.
REQ-032 say__RDY=0, enqueue tags=1 with v=1,2,3 back-to-back (DEPTH=2) -> RDY drops after 2nd accept, 3rd held by source; release RDY -> delivered v=1,2,3 in order.
REQ-033 BADTAG_EN defined, enqueue tag=2 then tag=1 v=9 -> only v=9 delivered, badtag$count=1; 2^CNT_W+3 bad tags -> count saturates at all-ones.
REQ-034 Buffer full, assert say__RDY and pipe ENA same cycle -> one delivery, no accept that cycle; accept succeeds next cycle; order preserved.
REQ-035 Buffer holds 2 messages, RST pulsed 1 cycle -> ENA=0 next cycle, count=0, pipe$enq__RDY=1, no stale message ever delivered.
REQ-036 BADTAG_EN undefined, enqueue tag=7 v=4 -> v=4 delivered, badtag$count stays 0.
